memory_cycle: RTL and testbench
===============================

Name: memory_cycle

Overview:
Memory pipeline stage. It receives the M-stage control and data registered by the execute stage and performs word loads and stores on a valid/ready data-memory bus. It stalls the upstream pipeline while an access is outstanding and drives the M/W pipeline register consumed by writeback. A wait-state counter with timeout and a misalignment check raise a sticky bus error.

Parameters:
TIMEOUT, 16, maximum wait cycles after request issue before abort (1..255).
CNT_W, $clog2(TIMEOUT+1), wait-counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
RegWriteM  in  1  register write enable for the M-stage instruction.
MemWriteM  in  1  store.
ResultSrcM  in  1  0 = ALU result, 1 = load data.
RD_M  in  5  destination register.
PCPlus4M  in  32  PC+4.
ALU_ResultM  in  32  effective address or ALU result.
WriteDataM  in  32  store data.
dmem_req  out  1  bus request.
dmem_we  out  1  bus write.
dmem_addr  out  32  word address.
dmem_wdata  out  32  store data.
dmem_rdata  in  32  load data, valid in the cycle dmem_ready=1.
dmem_ready  in  1  access complete.
StallM  out  1  freeze the F/D/E stages and the E/M register.
bus_err  out  1  sticky error flag.
RegWriteW  out  1  W-stage write enable.
ResultSrcW  out  1  W-stage result select.
RD_W  out  5  W-stage destination.
PCPlus4W  out  32  W-stage PC+4.
ALU_ResultW  out  32  W-stage ALU result.
ReadDataW  out  32  W-stage load data.

Behaviour:
- Memory op: mem_op = MemWriteM | ResultSrcM. Misaligned: ALU_ResultM[1:0] != 0.
- Reset (async, rst=1):
  - state=IDLE, counter=0, bus_err=0.
  - All W outputs and dmem_req/we/addr/wdata = 0.
  - Reset mid-access drops dmem_req in the same cycle, writes nothing to W, and discards the latched request.
- IDLE:
  - dmem_req = mem_op & ~misaligned (combinational). dmem_we = MemWriteM. Address and wdata come straight from the M inputs.
  - No mem_op: W register loads the M inputs next edge; StallM=0.
  - mem_op & misaligned: no request; bus_err<=1; W gets a bubble (RegWriteW<=0); StallM=0.
  - dmem_req & dmem_ready in the same cycle (zero-wait): W loads the M controls; ReadDataW<=dmem_rdata; StallM=0; stay IDLE.
  - dmem_req & ~dmem_ready: StallM=1. Latch we, addr, wdata, RegWrite, ResultSrc, RD, PCPlus4 and ALU_Result. counter<=1. Go to WAIT. W gets a bubble.
- WAIT:
  - dmem_req=1. Bus is driven from the latched values only; M inputs are ignored.
  - StallM=1 except in the completion cycle.
  - dmem_ready=1: StallM=0. W loads the latched controls; ReadDataW<=dmem_rdata. Go to IDLE.
  - ~dmem_ready and counter==TIMEOUT: StallM=0; dmem_req stays 1 this cycle. bus_err<=1; W gets a bubble. Go to IDLE; the instruction retires as a NOP.
  - Otherwise counter<=counter+1 and W gets a bubble.
- ready arriving together with the timeout count: ready wins; the access completes normally.
- dmem_ready while dmem_req=0 is ignored.
- bus_err is cleared only by reset.
- Latency: 1 cycle from M to W for non-memory and zero-wait accesses; N wait cycles add N stall cycles.
- ReadDataW retains its previous value for non-load instructions.
- StallM is combinational: (state==WAIT) & ~dmem_ready & (counter!=TIMEOUT), or (IDLE & dmem_req & ~dmem_ready). No other output is combinational from inputs except dmem_*.
- Exactly one W write per instruction; no double write on completion.

Decomposition:
- Shared package pipeline_pkg:
  - mem_state_t enum {IDLE, WAIT}.
  - Typedef wb_ctrl_t struct {RegWrite, ResultSrc, RD}.
  - Constants WORD_ALIGN_MASK=2'b11 and NOP_CTRL.
- One natural sub-module, mem_wait_timer: counter with clear, enable and expired outputs, parameterised by TIMEOUT. Everything else stays in memory_cycle.

Test Plan:
1. ALU op (RegWriteM=1, RD_M=5, ALU_ResultM=0x2A, ResultSrcM=0) → next edge RegWriteW=1, RD_W=5, ALU_ResultW=0x2A; StallM never 1.
2. Zero-wait load at 0x100 with ready=1 and rdata=0xDEADBEEF in the same cycle → dmem_req=1, dmem_we=0, addr=0x100; next edge ReadDataW=0xDEADBEEF, ResultSrcW=1; StallM=0.
3. Store at 0x40, data 0x1234, ready after 3 cycles, M inputs changed to garbage during the wait → addr and wdata stay 0x40/0x1234 for all cycles; StallM=1 for 3 cycles; RegWriteW=0 throughout; returns to IDLE.
4. Load with ready never asserted, TIMEOUT=4 → StallM high 4 cycles then drops; bus_err=1 and stays 1; RegWriteW=0; the next ALU op passes normally.
5. Misaligned load at 0x102 → dmem_req stays 0; bus_err=1; RegWriteW=0; no stall.
6. Assert rst in the 2nd wait cycle of a load → dmem_req=0 immediately; all W outputs 0; after release, state is IDLE and bus_err=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the memory pipeline stage: FSM state,
// writeback control bundle and the request latched while the bus is busy.
package pipeline_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic       reg_write;
    logic       result_src;
    logic [4:0] rd;
  } wb_ctrl_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  localparam wb_ctrl_t   NOP_CTRL        = '{reg_write: 1'b0, result_src: 1'b0, rd: 5'd0};

  // addr doubles as the ALU result forwarded to writeback on completion.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    wb_ctrl_t    ctrl;
    logic [31:0] pc_plus4;
  } mem_req_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for an outstanding bus access; expired flags that the
// count has reached TIMEOUT. clear takes priority over enable.
module mem_wait_timer #(
  parameter  int TIMEOUT = 16,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: issues word loads/stores on a valid/ready bus, stalls the
// front of the pipe while an access is outstanding, and drives the M/W register.
module memory_cycle
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        StallM,
  output logic        bus_err,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW
);

  mem_state_t  state_q, state_d;
  mem_req_t    req_q, req_d;
  wb_ctrl_t    w_ctrl_q, w_ctrl_d;
  logic [31:0] w_pc_q, w_pc_d;
  logic [31:0] w_alu_q, w_alu_d;
  logic [31:0] w_rdata_q, w_rdata_d;
  logic        bus_err_q, bus_err_d;

  logic        mem_op, misaligned;
  logic        tmr_clear, tmr_en, tmr_expired;
  wb_ctrl_t    m_ctrl;

  assign mem_op     = MemWriteM | ResultSrcM;
  assign misaligned = |(ALU_ResultM[1:0] & WORD_ALIGN_MASK);
  assign m_ctrl     = '{reg_write: RegWriteM, result_src: ResultSrcM, rd: RD_M};

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // NOTE: every signal written below gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    w_ctrl_d   = w_ctrl_q;
    w_pc_d     = w_pc_q;
    w_alu_d    = w_alu_q;
    w_rdata_d  = w_rdata_q;
    bus_err_d  = bus_err_q;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    StallM     = 1'b0;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        dmem_req   = mem_op & ~misaligned;
        dmem_we    = MemWriteM;
        dmem_addr  = ALU_ResultM;
        dmem_wdata = WriteDataM;
        if (!mem_op) begin
          w_ctrl_d = m_ctrl;
          w_pc_d   = PCPlus4M;
          w_alu_d  = ALU_ResultM;
        end else if (misaligned) begin
          bus_err_d = 1'b1;
          w_ctrl_d  = NOP_CTRL;
        end else if (dmem_ready) begin
          w_ctrl_d = m_ctrl;
          w_pc_d   = PCPlus4M;
          w_alu_d  = ALU_ResultM;
          if (ResultSrcM) w_rdata_d = dmem_rdata;
        end else begin
          StallM   = 1'b1;
          tmr_en   = 1'b1;
          state_d  = WAIT;
          w_ctrl_d = NOP_CTRL;
          req_d    = '{we: MemWriteM, addr: ALU_ResultM, wdata: WriteDataM,
                       ctrl: m_ctrl, pc_plus4: PCPlus4M};
        end
      end

      WAIT: begin
        // Bus keeps the latched request; the stalled M inputs are don't-care here.
        dmem_req   = 1'b1;
        dmem_we    = req_q.we;
        dmem_addr  = req_q.addr;
        dmem_wdata = req_q.wdata;
        if (dmem_ready) begin
          w_ctrl_d  = req_q.ctrl;
          w_pc_d    = req_q.pc_plus4;
          w_alu_d   = req_q.addr;
          if (req_q.ctrl.result_src) w_rdata_d = dmem_rdata;
          tmr_clear = 1'b1;
          state_d   = IDLE;
        end else if (tmr_expired) begin
          bus_err_d = 1'b1;
          w_ctrl_d  = NOP_CTRL;
          tmr_clear = 1'b1;
          state_d   = IDLE;
        end else begin
          StallM   = 1'b1;
          tmr_en   = 1'b1;
          w_ctrl_d = NOP_CTRL;
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset must drop the bus and stall in the same cycle, not at the next edge.
    if (rst) begin
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      StallM     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      w_ctrl_q  <= NOP_CTRL;
      w_pc_q    <= '0;
      w_alu_q   <= '0;
      w_rdata_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      w_ctrl_q  <= w_ctrl_d;
      w_pc_q    <= w_pc_d;
      w_alu_q   <= w_alu_d;
      w_rdata_q <= w_rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err     = bus_err_q;
  assign RegWriteW   = w_ctrl_q.reg_write;
  assign ResultSrcW  = w_ctrl_q.result_src;
  assign RD_W        = w_ctrl_q.rd;
  assign PCPlus4W    = w_pc_q;
  assign ALU_ResultW = w_alu_q;
  assign ReadDataW   = w_rdata_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle (TIMEOUT=4): ALU pass-through, zero-wait and
// wait-state accesses, timeout, misalignment, reset mid-access, ready/timeout tie.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        StallM, bus_err;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  int checks = 0;
  int errors = 0;

  memory_cycle #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready),
    .StallM      (StallM),
    .bus_err     (bus_err),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .PCPlus4W    (PCPlus4W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic set_m(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd);
    RegWriteM   = rw;
    MemWriteM   = mw;
    ResultSrcM  = rs;
    RD_M        = rd;
    PCPlus4M    = pc;
    ALU_ResultM = alu;
    WriteDataM  = wd;
  endtask

  // Inputs change at negedge; combinational outputs sampled 1 time unit later,
  // registered outputs sampled 1 time unit after the following posedge.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    set_m(1'b1, 1'b1, 1'b0, 5'd1, 32'h4, 32'h8, 32'h9);
    #3;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_stall", 32'(StallM), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_regwrite_w", 32'(RegWriteW), 32'd0);
    check("rst_alu_w", ALU_ResultW, 32'd0);

    // 1: ALU op passes straight to W
    @(negedge clk);
    rst = 1'b0;
    set_m(1'b1, 1'b0, 1'b0, 5'd5, 32'h10, 32'h2A, 32'h0);
    #1;
    check("alu_stall", 32'(StallM), 32'd0);
    check("alu_req", 32'(dmem_req), 32'd0);
    after_edge();
    check("alu_regwrite_w", 32'(RegWriteW), 32'd1);
    check("alu_rd_w", 32'(RD_W), 32'd5);
    check("alu_result_w", ALU_ResultW, 32'h2A);
    check("alu_pc_w", PCPlus4W, 32'h10);

    // 2: zero-wait load
    @(negedge clk);
    set_m(1'b1, 1'b0, 1'b1, 5'd6, 32'h14, 32'h100, 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    check("zw_req", 32'(dmem_req), 32'd1);
    check("zw_we", 32'(dmem_we), 32'd0);
    check("zw_addr", dmem_addr, 32'h100);
    check("zw_stall", 32'(StallM), 32'd0);
    after_edge();
    check("zw_rdata_w", ReadDataW, 32'hDEADBEEF);
    check("zw_resultsrc_w", 32'(ResultSrcW), 32'd1);
    check("zw_regwrite_w", 32'(RegWriteW), 32'd1);
    check("zw_rd_w", 32'(RD_W), 32'd6);

    // 3: store with 3 stall cycles, garbage on M inputs while waiting
    @(negedge clk);
    set_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h18, 32'h40, 32'h1234);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    #1;
    check("st_req", 32'(dmem_req), 32'd1);
    check("st_we", 32'(dmem_we), 32'd1);
    check("st_addr", dmem_addr, 32'h40);
    check("st_wdata", dmem_wdata, 32'h1234);
    check("st_stall0", 32'(StallM), 32'd1);
    after_edge();
    check("st_regwrite_w0", 32'(RegWriteW), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_m(1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'h0BAD);
      #1;
      check("st_wait_req", 32'(dmem_req), 32'd1);
      check("st_wait_we", 32'(dmem_we), 32'd1);
      check("st_wait_addr", dmem_addr, 32'h40);
      check("st_wait_wdata", dmem_wdata, 32'h1234);
      check("st_wait_stall", 32'(StallM), 32'd1);
      after_edge();
      check("st_wait_regwrite_w", 32'(RegWriteW), 32'd0);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h5555_5555;
    #1;
    check("st_done_addr", dmem_addr, 32'h40);
    check("st_done_wdata", dmem_wdata, 32'h1234);
    check("st_done_stall", 32'(StallM), 32'd0);
    after_edge();
    check("st_done_regwrite_w", 32'(RegWriteW), 32'd0);
    check("st_done_rdata_kept", ReadDataW, 32'hDEADBEEF);
    @(negedge clk);
    dmem_ready = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    check("st_idle_req", 32'(dmem_req), 32'd0);
    check("st_idle_stall", 32'(StallM), 32'd0);

    // 4: load that never gets ready -> 4 stall cycles, then abort
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_m(1'b1, 1'b0, 1'b1, 5'd7, 32'h20, 32'h200, 32'h0);
      #1;
      check("to_req", 32'(dmem_req), 32'd1);
      check("to_addr", dmem_addr, 32'h200);
      check("to_stall", 32'(StallM), (i < 4) ? 32'd1 : 32'd0);
      after_edge();
      check("to_regwrite_w", 32'(RegWriteW), 32'd0);
      check("to_bus_err", 32'(bus_err), (i < 4) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    set_m(1'b1, 1'b0, 1'b0, 5'd9, 32'h24, 32'h77, 32'h0);
    #1;
    check("to_next_stall", 32'(StallM), 32'd0);
    check("to_next_req", 32'(dmem_req), 32'd0);
    after_edge();
    check("to_next_regwrite_w", 32'(RegWriteW), 32'd1);
    check("to_next_rd_w", 32'(RD_W), 32'd9);
    check("to_next_alu_w", ALU_ResultW, 32'h77);
    check("to_bus_err_sticky", 32'(bus_err), 32'd1);

    // clear the sticky error before the misalignment case
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst2_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 5: misaligned load; a stray ready must be ignored
    set_m(1'b1, 1'b0, 1'b1, 5'd2, 32'h28, 32'h102, 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h1111_2222;
    #1;
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_stall", 32'(StallM), 32'd0);
    after_edge();
    check("mis_bus_err", 32'(bus_err), 32'd1);
    check("mis_regwrite_w", 32'(RegWriteW), 32'd0);
    check("mis_rdata_kept", ReadDataW, 32'd0);

    // 6: reset in the 2nd wait cycle of a load
    @(negedge clk);
    dmem_ready = 1'b0;
    set_m(1'b1, 1'b0, 1'b0, 5'd4, 32'h2C, 32'h55, 32'h0);
    after_edge();
    check("pre_rst_alu_w", ALU_ResultW, 32'h55);
    @(negedge clk);
    set_m(1'b1, 1'b0, 1'b1, 5'd3, 32'h30, 32'h300, 32'h0);
    after_edge();
    @(negedge clk);
    #1;
    check("rw_wait2_stall", 32'(StallM), 32'd1);
    check("rw_wait2_req", 32'(dmem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rw_req", 32'(dmem_req), 32'd0);
    check("rw_stall", 32'(StallM), 32'd0);
    check("rw_regwrite_w", 32'(RegWriteW), 32'd0);
    check("rw_rd_w", 32'(RD_W), 32'd0);
    check("rw_pc_w", PCPlus4W, 32'd0);
    check("rw_alu_w", ALU_ResultW, 32'd0);
    check("rw_rdata_w", ReadDataW, 32'd0);
    check("rw_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h9999_9999;
    rst = 1'b0;
    #1;
    check("rw_post_req", 32'(dmem_req), 32'd0);
    check("rw_post_stall", 32'(StallM), 32'd0);
    after_edge();
    check("rw_post_regwrite_w", 32'(RegWriteW), 32'd0);
    check("rw_post_rdata_w", ReadDataW, 32'd0);
    @(negedge clk);
    set_m(1'b1, 1'b0, 1'b1, 5'd10, 32'h34, 32'h400, 32'h0);
    dmem_rdata = 32'hCAFEF00D;
    #1;
    check("rw_zw_req", 32'(dmem_req), 32'd1);
    check("rw_zw_addr", dmem_addr, 32'h400);
    check("rw_zw_stall", 32'(StallM), 32'd0);
    after_edge();
    check("rw_zw_rdata_w", ReadDataW, 32'hCAFEF00D);
    check("rw_zw_bus_err", 32'(bus_err), 32'd0);

    // 7: ready arrives together with the timeout count -> completes normally
    @(negedge clk);
    dmem_ready = 1'b0;
    set_m(1'b1, 1'b0, 1'b1, 5'd8, 32'h38, 32'h500, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("tie_stall", 32'(StallM), 32'd1);
      after_edge();
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h600DF00D;
    #1;
    check("tie_done_stall", 32'(StallM), 32'd0);
    check("tie_done_req", 32'(dmem_req), 32'd1);
    after_edge();
    check("tie_regwrite_w", 32'(RegWriteW), 32'd1);
    check("tie_rd_w", 32'(RD_W), 32'd8);
    check("tie_rdata_w", ReadDataW, 32'h600DF00D);
    check("tie_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    dmem_ready = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    after_edge();
    check("tie_single_write", 32'(RegWriteW), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
